// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM states, single-iteration datapath modes and special-case divide results.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    MD_STEP_MUL = 1'b0,
    MD_STEP_DIV = 1'b1
  } md_step_e;

  // 32-bit reference values; the unit widens them to XLEN
  localparam logic [31:0] MD_DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_OVF_QUOT  = 32'h8000_0000;
  localparam logic [31:0] MD_OVF_REM   = 32'h0000_0000;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multi-cycle datapath: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  md_step_e          mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] trial;

  // Multiply: acc = {partial high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend bits / quotient}.
  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    case (mode)
      MD_STEP_MUL: acc_next = {add_sum, acc[XLEN-1:1]};
      MD_STEP_DIV: begin
        if (trial[XLEN]) begin
          acc_next = {acc[2*XLEN-2:0], 1'b0};
        end else begin
          acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
      end
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for all multiply ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            kill,
  output logic            muldiv_busy,
  output logic            muldiv_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{MD_DIV0_QUOT[0]}};
  localparam logic [XLEN-1:0] OVF_QUOT  = {MD_OVF_QUOT[31], {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] OVF_REM   = {XLEN{MD_OVF_REM[0]}};
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

  md_state_e         state;
  md_state_e         state_next;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              sign_x_q;
  logic              sign_a_q;

  logic              rs1_signed;
  logic              rs2_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div0;
  logic              ovf;
  logic              take_fast;
  logic [XLEN-1:0]   fast_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  md_step_e          step_mode;
  logic [2*XLEN-1:0] step_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  // Operand sign/magnitude decode and single-cycle results for the IDLE exit
  always_comb begin
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
      end
      MD_MULHSU: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b0;
      end
      default: begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
      end
    endcase
    a_neg = rs1_signed & rs1_data[XLEN-1];
    b_neg = rs2_signed & rs2_data[XLEN-1];
    a_mag = a_neg ? -rs1_data : rs1_data;
    b_mag = b_neg ? -rs2_data : rs2_data;
    div0  = op[2] && (rs2_data == {XLEN{1'b0}});
    ovf   = ((op == MD_DIV) || (op == MD_REM)) && (rs1_data == OVF_QUOT) && (rs2_data == ALL_ONES);
    take_fast = div0 | ovf;
    if (div0) begin
      fast_res = op[1] ? rs1_data : DIV0_QUOT;
    end else if (ovf) begin
      fast_res = op[1] ? OVF_REM : OVF_QUOT;
    end else begin
      fast_res = {XLEN{1'b0}};
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    if (a_neg ^ b_neg) begin
      fast_prod = -fast_prod;
    end else begin
      fast_prod = fast_prod;
    end
    if (!op[2]) begin
      take_fast = 1'b1;
      fast_res  = (op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end else begin
      take_fast = take_fast;
    end
`endif
  end

  assign step_mode = op_q[2] ? MD_STEP_DIV : MD_STEP_MUL;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .mode     (step_mode),
    .acc_next (step_next)
  );

  // Sign correction and result select applied to the last iteration's output
  always_comb begin
    prod_fix = sign_x_q ? -step_next : step_next;
    quot_fix = sign_x_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    rem_fix  = sign_a_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                      final_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             final_res = quot_fix;
      default:                     final_res = rem_fix;
    endcase
  end

  // Next-state logic; kill overrides everything
  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state_next = take_fast ? MD_DONE : MD_CALC;
          end else begin
            state_next = MD_IDLE;
          end
        end
        MD_CALC: begin
          if (count == CW'(1)) begin
            state_next = MD_DONE;
          end else begin
            state_next = MD_CALC;
          end
        end
        MD_DONE: state_next = MD_IDLE;
        default: state_next = MD_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= {CW{1'b0}};
      op_q     <= 3'b000;
      acc      <= {(2*XLEN){1'b0}};
      opnd     <= {XLEN{1'b0}};
      sign_x_q <= 1'b0;
      sign_a_q <= 1'b0;
      result   <= {XLEN{1'b0}};
    end else if (!kill) begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_q     <= op;
            sign_x_q <= a_neg ^ b_neg;
            sign_a_q <= a_neg;
            count    <= CW'(XLEN);
            if (take_fast) begin
              result <= fast_res;
            end else if (op[2]) begin
              acc  <= {{XLEN{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{XLEN{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end
        end
        MD_CALC: begin
          acc   <= step_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign muldiv_busy  = (state == MD_CALC);
  assign muldiv_ready = (state == MD_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a
// per-cycle output compare plus directed vectors with literal expectations.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic        kill = 1'b0;
  logic        muldiv_busy;
  logic        muldiv_ready;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .kill         (kill),
    .muldiv_busy  (muldiv_busy),
    .muldiv_ready (muldiv_ready),
    .result       (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_calc(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    logic [63:0] p;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = 64'h0;
    case (o)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      MD_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      MD_DIVU: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    if (o[2]) begin
      if (b == 32'h0) return 1;
      if ((o == MD_DIV || o == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Reference model: expected outputs as a function of cycles since acceptance
  logic        m_busy = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_active = 1'b0;
  logic [31:0] m_res = 32'h0;
  logic [31:0] m_pend = 32'h0;
  int          m_n = 0;
  int          m_lat = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_busy = 1'b0; m_ready = 1'b0; m_res = 32'h0;
    end else if (kill) begin
      m_active = 1'b0; m_busy = 1'b0; m_ready = 1'b0;
    end else if (m_ready) begin
      m_ready = 1'b0;
    end else if (m_active) begin
      m_n = m_n + 1;
      if (m_n == m_lat) begin
        m_active = 1'b0; m_busy = 1'b0; m_ready = 1'b1; m_res = m_pend;
      end
    end else if (start) begin
      m_pend = ref_calc(op, rs1_data, rs2_data);
      m_lat  = exp_lat(op, rs1_data, rs2_data);
      m_n    = 1;
      if (m_lat == 1) begin
        m_ready = 1'b1; m_res = m_pend;
      end else begin
        m_active = 1'b1; m_busy = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    check("cyc_busy",   {31'h0, muldiv_busy},  {31'h0, m_busy});
    check("cyc_ready",  {31'h0, muldiv_ready}, {31'h0, m_ready});
    check("cyc_result", result, m_res);
  end

  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int lat);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b;
    while (n < 40 && !(n > 0 && muldiv_ready)) begin
      @(negedge clk);
      n = n + 1;
      if (muldiv_busy) busy_cnt = busy_cnt + 1;
    end
    start = 1'b0;
    if (!muldiv_ready) begin
      check({name, "_timeout"}, 32'h0, 32'h1);
    end else begin
      check({name, "_res"}, result, exp_res);
      check({name, "_lat"}, n, lat);
      check({name, "_busy"}, busy_cnt, lat - 1);
      @(negedge clk);
      check({name, "_one_pulse"}, {31'h0, muldiv_ready}, 32'h0);
    end
  endtask

  int mul_lat;
  logic [31:0] prev;

  initial begin
`ifdef MULDIV_FAST_MUL_EN
    mul_lat = 1;
`else
    mul_lat = 33;
`endif
    // Pin the model with hand-computed values
    check("model_mul",    ref_calc(MD_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model_mulhsu", ref_calc(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("model_div",    ref_calc(MD_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem",    ref_calc(MD_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    check("reset_busy",   {31'h0, muldiv_busy}, 32'h0);
    check("reset_ready",  {31'h0, muldiv_ready}, 32'h0);
    check("reset_result", result, 32'h0);
    rst = 1'b0;

    do_op("mul_neg",   MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, mul_lat);
    do_op("mulh_min",  MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, mul_lat);
    do_op("mulhu_min", MD_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, mul_lat);
    do_op("mulhsu_m1", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mul_lat);
    do_op("div_ovf",   MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",   MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    do_op("divu_zero", MD_DIVU,   32'h0000_1234, 32'h0,         32'hFFFF_FFFF, 1);
    do_op("remu_zero", MD_REMU,   32'h0000_1234, 32'h0,         32'h0000_1234, 1);
    do_op("rem_zero",  MD_REM,    32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 1);
    do_op("div_m7",    MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    do_op("rem_m7",    MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    do_op("divu_100",  MD_DIVU,   32'd100,      32'd7,          32'd14,        33);
    do_op("remu_100",  MD_REMU,   32'd100,      32'd7,          32'd2,         33);

    // Kill in the middle of a divide
    prev = result;
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; rs1_data = 32'h0000_1000; rs2_data = 32'd3;
    repeat (10) @(negedge clk);
    kill = 1'b1; start = 1'b0;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy",   {31'h0, muldiv_busy}, 32'h0);
    check("kill_ready",  {31'h0, muldiv_ready}, 32'h0);
    check("kill_result", result, prev);
    repeat (3) @(negedge clk);
    do_op("divu_after_kill", MD_DIVU, 32'h0000_1000, 32'd3, 32'h0000_0555, 33);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   {31'h0, muldiv_busy}, 32'h0);
    check("arst_ready",  {31'h0, muldiv_ready}, 32'h0);
    check("arst_result", result, 32'h0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op("mul_3x5", MD_MUL, 32'd3, 32'd5, 32'd15, mul_lat);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
